// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared FSM encodings and word-packing constants for the instruction loader
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int          DEFAULT_SIZE      = 32;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = DEFAULT_SIZE / 8;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// rtl/instruction_loader_word_assembler.sv - packs bytes MSB-first into words, flags the completing byte
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int BYTES = BYTES_PER_WORD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_valid,
  input  logic [7:0]      i_data,
  output logic [SIZE-1:0] o_word,
  output logic            o_word_valid
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

  logic [SIZE-1:0] word;
  logic [CW-1:0]   byte_cnt;

  // Word and valid are presented in the cycle the last byte arrives so the
  // parent can register the write one cycle later.
  assign o_word       = {word[SIZE-9:0], i_data};
  assign o_word_valid = i_valid && (byte_cnt == LAST_BYTE);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (i_valid) begin
      word     <= o_word;
      byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads a UART byte stream into instruction memory, word by word from address 0
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int              SIZE            = DEFAULT_SIZE,
  parameter int              MAX_INSTRUCTION = 64,
  parameter logic [SIZE-1:0] HALT_WORD       = DEFAULT_HALT_WORD,
  parameter int              TIMEOUT_CYCLES  = 100000,
  localparam int             ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic                  o_timeout,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] MAX_COUNT    = (ADDR_WIDTH + 1)'(MAX_INSTRUCTION);
  localparam logic [TW-1:0]       TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TW-1:0]   idle_cnt;
  logic [SIZE-1:0] asm_word;
  logic            asm_valid;
  logic            asm_in_valid;
  logic            asm_clear;
  logic            timeout_hit;

  assign timeout_hit  = (state == ST_RECV) && !i_rx_valid && (idle_cnt == TIMEOUT_LAST);
  // Holding the assembler clear outside RECV gives every session a fresh partial word.
  assign asm_clear    = (state != ST_RECV) || timeout_hit;
  assign asm_in_valid = i_rx_valid && (state == ST_RECV);
  assign o_busy       = (state != ST_IDLE);

  word_assembler #(
    .SIZE (SIZE),
    .BYTES(SIZE / 8)
  ) u_word_assembler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (asm_clear),
    .i_valid     (asm_in_valid),
    .i_data      (i_rx_data),
    .o_word      (asm_word),
    .o_word_valid(asm_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      idle_cnt            <= '0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_done              <= 1'b0;
      o_overflow          <= 1'b0;
      o_timeout           <= 1'b0;
      o_word_count        <= '0;
    end else begin
      o_inst_write_enable <= 1'b0;
      o_done              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state        <= ST_RECV;
            idle_cnt     <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
            o_timeout    <= 1'b0;
          end
        end
        ST_RECV: begin
          idle_cnt <= i_rx_valid ? '0 : idle_cnt + 1'b1;
          if (timeout_hit) begin
            o_timeout <= 1'b1;
            state     <= ST_FINISH;
          end else if (asm_valid) begin
            // A full memory is reported, never wrapped back onto word 0.
            if (o_word_count == MAX_COUNT) begin
              o_overflow <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              o_inst_write_enable <= 1'b1;
              o_write_addr        <= o_word_count[ADDR_WIDTH-1:0];
              o_write_data        <= asm_word;
              o_word_count        <= o_word_count + 1'b1;
              if (asm_word == HALT_WORD) state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic        a_we, a_busy, a_done, a_ovf, a_to;
  logic [5:0]  a_addr;
  logic [31:0] a_data;
  logic [6:0]  a_cnt;

  logic        b_we, b_busy, b_done, b_ovf, b_to;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  logic [5:0]  qa_addr[$];
  logic [31:0] qa_data[$];
  logic [1:0]  qb_addr[$];
  logic [31:0] qb_data[$];
  int          a_done_cnt = 0;

  logic [7:0]  prog[12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [31:0] prog_words[3] = '{32'h2008_0005, 32'h2009_0007, 32'hFFFF_FFFF};
  logic [31:0] ovf_words[5]  = '{32'h0102_0304, 32'h1112_1314, 32'h2122_2324,
                                 32'h3132_3334, 32'h4142_4344};

  always #5 clk = ~clk;

  instruction_loader dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_inst_write_enable(a_we), .o_write_addr(a_addr), .o_write_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf), .o_timeout(a_to),
    .o_word_count(a_cnt)
  );

  instruction_loader #(.MAX_INSTRUCTION(4), .TIMEOUT_CYCLES(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_inst_write_enable(b_we), .o_write_addr(b_addr), .o_write_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf), .o_timeout(b_to),
    .o_word_count(b_cnt)
  );

  always @(negedge clk) begin
    if (a_we) begin
      qa_addr.push_back(a_addr);
      qa_data.push_back(a_data);
    end
    if (b_we) begin
      qb_addr.push_back(b_addr);
      qb_data.push_back(b_data);
    end
    if (a_done) a_done_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    a_done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if ({a_we, a_busy, a_done, a_ovf, a_to} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {a_we, a_busy, a_done, a_ovf, a_to}); end
    checks++; if (a_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", a_addr); end
    checks++; if (a_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", a_data); end
    checks++; if (a_cnt !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", a_busy); end
    for (int i = 0; i < 12; i++) send_byte(prog[i]);
    checks++; if (a_we !== 1'b1 || a_addr !== 6'd2 || a_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_halt_write got we=%b addr=%0d data=%h exp we=1 addr=2 data=ffffffff", a_we, a_addr, a_data); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_done_early got %b exp 0", a_done); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_we !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%b we=%b exp done=1 we=0", a_done, a_we); end
    checks++; if (a_cnt !== 7'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", a_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (qa_addr.size() !== 3) begin errors++; $display("FAIL b2b_nwrites got %0d exp 3", qa_addr.size()); end
    for (int i = 0; i < 3 && i < qa_addr.size(); i++) begin
      checks++; if (qa_addr[i] !== 6'(i) || qa_data[i] !== prog_words[i]) begin errors++; $display("FAIL b2b_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, qa_addr[i], qa_data[i], i, prog_words[i]); end
    end
    checks++; if (a_done_cnt !== 1 || a_busy !== 1'b0 || a_cnt !== 7'd3) begin errors++; $display("FAIL b2b_after got dones=%0d busy=%b count=%0d exp 1 0 3", a_done_cnt, a_busy, a_cnt); end
  endtask

  task automatic test_random_gaps();
    int gap;
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      send_byte(prog[i]);
      checks++; if (a_we !== (i % 4 == 3)) begin errors++; $display("FAIL gaps_pulse byte%0d got %b exp %b", i, a_we, (i % 4 == 3)); end
      if (i != 11) begin
        gap = $urandom_range(0, 5);
        for (int k = 0; k < gap; k++) begin
          @(negedge clk);
          checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL gaps_idle_pulse byte%0d got %b exp 0", i, a_we); end
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (qa_addr.size() !== 3 || a_done_cnt !== 1) begin errors++; $display("FAIL gaps_counts got writes=%0d dones=%0d exp 3 1", qa_addr.size(), a_done_cnt); end
    for (int i = 0; i < 3 && i < qa_addr.size(); i++) begin
      checks++; if (qa_addr[i] !== 6'(i) || qa_data[i] !== prog_words[i]) begin errors++; $display("FAIL gaps_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, qa_addr[i], qa_data[i], i, prog_words[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      w = ovf_words[i];
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
      if (i == 3) begin
        checks++; if (b_we !== 1'b1 || b_addr !== 2'd3) begin errors++; $display("FAIL ovf_last_write got we=%b addr=%0d exp 1 3", b_we, b_addr); end
      end
    end
    checks++; if (b_we !== 1'b0 || b_ovf !== 1'b1 || b_busy !== 1'b1) begin errors++; $display("FAIL ovf_flag got we=%b ovf=%b busy=%b exp 0 1 1", b_we, b_ovf, b_busy); end
    @(negedge clk);
    checks++; if (b_done !== 1'b1 || b_cnt !== 3'd4) begin errors++; $display("FAIL ovf_done got done=%b count=%0d exp 1 4", b_done, b_cnt); end
    checks++; if (qb_addr.size() !== 4) begin errors++; $display("FAIL ovf_nwrites got %0d exp 4", qb_addr.size()); end
    for (int i = 0; i < 4 && i < qb_addr.size(); i++) begin
      checks++; if (qb_addr[i] !== 2'(i) || qb_data[i] !== ovf_words[i]) begin errors++; $display("FAIL ovf_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, qb_addr[i], qb_data[i], i, ovf_words[i]); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", b_to); end
      end
      if (k == 16) begin
        checks++; if (b_to !== 1'b1 || b_done !== 1'b0) begin errors++; $display("FAIL to_flag got to=%b done=%b exp 1 0", b_to, b_done); end
      end
      if (k == 17) begin
        checks++; if (b_done !== 1'b1 || b_to !== 1'b1) begin errors++; $display("FAIL to_done got done=%b to=%b exp 1 1", b_done, b_to); end
      end
    end
    checks++; if (qb_addr.size() !== 0 || b_cnt !== 3'd0) begin errors++; $display("FAIL to_nowrite got writes=%0d count=%0d exp 0 0", qb_addr.size(), b_cnt); end
    pulse_start();
    checks++; if (b_to !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL to_clear got to=%b busy=%b exp 0 1", b_to, b_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(prog[i]);
    rst = 1'b1; rx_data = 8'h05; rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    checks++; if ({a_we, a_busy, a_done, a_ovf, a_to} !== 5'b0 || a_cnt !== 7'd0 || a_addr !== 6'd0 || a_data !== 32'd0) begin errors++; $display("FAIL rstmid_outputs got flags=%b cnt=%0d addr=%0d data=%h exp all 0", {a_we, a_busy, a_done, a_ovf, a_to}, a_cnt, a_addr, a_data); end
    repeat (2) @(negedge clk);
    checks++; if (qa_addr.size() !== 0 || a_done_cnt !== 0) begin errors++; $display("FAIL rstmid_quiet got writes=%0d dones=%0d exp 0 0", qa_addr.size(), a_done_cnt); end
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h12 + 8'(i * 8'h22));
    checks++; if (a_we !== 1'b1 || a_addr !== 6'd0 || a_data !== 32'h1234_5678) begin errors++; $display("FAIL rstmid_fresh got we=%b addr=%0d data=%h exp 1 0 12345678", a_we, a_addr, a_data); end
  endtask

  task automatic test_ignored();
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hAA + 8'(i * 8'h11));
    @(negedge clk);
    checks++; if (qa_addr.size() !== 0 || a_busy !== 1'b0) begin errors++; $display("FAIL ign_idle_rx got writes=%0d busy=%b exp 0 0", qa_addr.size(), a_busy); end
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h08);
    pulse_start();
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    repeat (3) @(negedge clk);
    checks++; if (qa_addr.size() !== 2 || a_done_cnt !== 1) begin errors++; $display("FAIL ign_counts got writes=%0d dones=%0d exp 2 1", qa_addr.size(), a_done_cnt); end
    if (qa_addr.size() == 2) begin
      checks++; if (qa_addr[0] !== 6'd0 || qa_data[0] !== 32'h2008_0005) begin errors++; $display("FAIL ign_word0 got addr=%0d data=%h exp 0 20080005", qa_addr[0], qa_data[0]); end
      checks++; if (qa_addr[1] !== 6'd1 || qa_data[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ign_word1 got addr=%0d data=%h exp 1 ffffffff", qa_addr[1], qa_data[1]); end
    end
    checks++; if (a_cnt !== 7'd2) begin errors++; $display("FAIL ign_count got %0d exp 2", a_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_random_gaps();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
